// File: rtl/core_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use / RAW stalls, redirect flush, EX forwarding selects.
// Latency: STALL/BUBBLE/FLUSH are combinational from ID and slot state; FWD_SEL and HAZ_CNT are registered (1 cycle).
// Backpressure: MEM_BUSY freezes the slots, selects and counter and holds the front end (STALL=1, BUBBLE=0).
//
// Optional feature macro: FORWARDING_EN
//   defined   - EX/MEM results are forwarded; only load-use (and WB when RF_WRITE_FIRST=0) stalls.
//   undefined - any EX/MEM match stalls until the producer leaves MEM; FWD_SEL1/2 are tied to 00.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   ID_VALID .. ID_ISLOAD     decode-stage operand/destination info
//   EX_REDIRECT, MEM_BUSY     taken branch/jump in EX, data memory not ready
//   STALL, BUBBLE, FLUSH      IF/ID hold, ID/EX NOP insert, IF/ID kill
//   FWD_SEL1, FWD_SEL2        EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   HAZ_CNT                   saturating count of hazard-stall cycles
module core_hazard_ctrl #(
  parameter int unsigned RF_WRITE_FIRST = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ID_VALID,
  input  logic [4:0]       ID_RADDR1,
  input  logic [4:0]       ID_RADDR2,
  input  logic             ID_REG1_READ,
  input  logic             ID_REG2_READ,
  input  logic             ID_AWVALID,
  input  logic [4:0]       ID_AWADDR,
  input  logic             ID_ISLOAD,
  input  logic             EX_REDIRECT,
  input  logic             MEM_BUSY,
  output logic             STALL,
  output logic             BUBBLE,
  output logic             FLUSH,
  output logic [1:0]       FWD_SEL1,
  output logic [1:0]       FWD_SEL2,
  output logic [CNT_W-1:0] HAZ_CNT
);

  typedef struct packed {
    logic       vld;
    logic [4:0] addr;
    logic       ld;
  } slot_t;

  // A WB-slot producer is only a hazard when the register file cannot bypass its own write port.
  localparam bit WB_STALL = (RF_WRITE_FIRST == 0);

  slot_t            r_ex;
  slot_t            r_mem;
  slot_t            r_wb;
  logic [CNT_W-1:0] r_cnt;

  logic w_h1_ex, w_h1_mem, w_h1_wb;
  logic w_h2_ex, w_h2_mem, w_h2_wb;
  logic w_hz;
  logic w_issue;

  // x0 is hard-wired zero, so a read of x0 never depends on anything in flight.
  function automatic logic src_hit(input logic id_vld, input logic rd_en,
                                   input logic [4:0] ra, input slot_t s);
    return id_vld & rd_en & (ra != 5'd0) & s.vld & (s.addr == ra);
  endfunction

  assign w_h1_ex  = src_hit(ID_VALID, ID_REG1_READ, ID_RADDR1, r_ex);
  assign w_h1_mem = src_hit(ID_VALID, ID_REG1_READ, ID_RADDR1, r_mem);
  assign w_h1_wb  = src_hit(ID_VALID, ID_REG1_READ, ID_RADDR1, r_wb);
  assign w_h2_ex  = src_hit(ID_VALID, ID_REG2_READ, ID_RADDR2, r_ex);
  assign w_h2_mem = src_hit(ID_VALID, ID_REG2_READ, ID_RADDR2, r_mem);
  assign w_h2_wb  = src_hit(ID_VALID, ID_REG2_READ, ID_RADDR2, r_wb);

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time: its data appears at the end of MEM.
  assign w_hz = (r_ex.ld & (w_h1_ex | w_h2_ex))
              | (WB_STALL & (w_h1_wb | w_h2_wb));
`else
  assign w_hz = w_h1_ex | w_h2_ex | w_h1_mem | w_h2_mem
              | (WB_STALL & (w_h1_wb | w_h2_wb));
`endif

  assign w_issue = ID_VALID & ~MEM_BUSY & ~EX_REDIRECT & ~w_hz;

  always_comb begin
    STALL  = 1'b0;
    BUBBLE = 1'b0;
    FLUSH  = 1'b0;
    if (!RST) begin
      if (MEM_BUSY) begin
        STALL = 1'b1;
      end else if (EX_REDIRECT) begin
        // The ID instruction is on the wrong path, so a pending hazard on it is moot.
        FLUSH  = 1'b1;
        BUBBLE = 1'b1;
      end else if (w_hz) begin
        STALL  = 1'b1;
        BUBBLE = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
      r_cnt <= '0;
    end else if (!MEM_BUSY) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_issue) begin
        r_ex <= '{vld: ID_AWVALID, addr: ID_AWADDR, ld: ID_ISLOAD};
      end else begin
        r_ex <= '0;
      end
      if (w_hz && !EX_REDIRECT && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign HAZ_CNT = r_cnt;

`ifdef FORWARDING_EN
  logic [1:0] r_fwd1;
  logic [1:0] r_fwd2;
  logic       w_unused_ld;

  // The load flag only matters while the producer sits in EX.
  assign w_unused_ld = r_mem.ld ^ r_wb.ld;

  // Youngest producer wins: the EX slot holds the newer value of a register written twice.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fwd1 <= 2'b00;
      r_fwd2 <= 2'b00;
    end else if (!MEM_BUSY) begin
      r_fwd1 <= !w_issue ? 2'b00 : w_h1_ex ? 2'b01 : w_h1_mem ? 2'b10 : 2'b00;
      r_fwd2 <= !w_issue ? 2'b00 : w_h2_ex ? 2'b01 : w_h2_mem ? 2'b10 : 2'b00;
    end
  end

  assign FWD_SEL1 = r_fwd1;
  assign FWD_SEL2 = r_fwd2;
`else
  logic w_unused_ld;

  assign w_unused_ld = r_ex.ld ^ r_mem.ld ^ r_wb.ld;
  assign FWD_SEL1    = 2'b00;
  assign FWD_SEL2    = 2'b00;
`endif

endmodule
